// File: rtl/wvb_evt_reader.sv
// wvb_evt_reader: pops a waveform header and its samples, streams them as 16-bit words.
// Optional WVB_RD_DISCR_EN appends a discriminator word after every sample word.
`default_nettype none

module wvb_evt_reader #(
  parameter int RD_LAT  = 1,
  parameter int OFIFO_D = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  n_wvf_in_buf,
  input  logic [79:0] hdr_data,
  output logic        hdr_rdreq,
  input  logic [21:0] wvb_data,
  output logic        wvb_rdreq,
  output logic        wvb_rddone,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy,
  output logic        err_eoe,
  output logic [15:0] evt_cnt
);

  localparam int AW = $clog2(OFIFO_D);
`ifdef WVB_RD_DISCR_EN
  localparam int WPS = 2;
`else
  localparam int WPS = 1;
`endif
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(OFIFO_D);
  localparam logic [15:0] CREDIT_C = 16'(OFIFO_D - WPS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_HDRW = 3'd2;
  localparam logic [2:0] S_SMP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [2:0]        hw_idx_q, hw_idx_d;
  logic [15:0]       w0_q, w0_d;
  logic [47:0]       ltc_q, ltc_d;
  logic [12:0]       len_q, len_d;
  logic [12:0]       issue_q, issue_d;
  logic [12:0]       recv_q, recv_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic              hdr_rdreq_q, hdr_rdreq_d;
  logic              wvb_rdreq_q, wvb_rdreq_d;
  logic              err_q, err_d;
  logic [15:0]       evt_cnt_q, evt_cnt_d;
  logic [16:0]       mem_q [OFIFO_D];
  logic [16:0]       mem_d [OFIFO_D];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;

  logic        push0, push1, pop, is_last, eoe;
  logic [16:0] d0, d1;
  logic [3:0]  in_flight;
  logic [15:0] committed;
  logic [11:0] len_diff;
  logic [16:0] head;

  assign head     = mem_q[rd_ptr_q];
  assign pop      = (cnt_q != '0) && dout_ready;
  assign len_diff = hdr_data[19:8] - hdr_data[31:20];
  assign eoe      = wvb_data[0];
  assign is_last  = (recv_q == len_q - 13'd1);

`ifndef WVB_RD_DISCR_EN
  logic discr_unused;
  assign discr_unused = ^wvb_data[21:14];
`endif

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    hw_idx_d    = hw_idx_q;
    w0_d        = w0_q;
    ltc_d       = ltc_q;
    len_d       = len_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    err_d       = err_q;
    evt_cnt_d   = evt_cnt_q;
    hdr_rdreq_d = 1'b0;
    wvb_rdreq_d = 1'b0;
    push0       = 1'b0;
    push1       = 1'b0;
    d0          = '0;
    d1          = '0;

    rd_pipe_d[0] = wvb_rdreq_q;
    for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];

    // Words already buffered plus words still owed by outstanding pops.
    in_flight = {3'b0, wvb_rdreq_q};
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + {3'b0, rd_pipe_q[i]};
    committed = 16'(cnt_q) + 16'(WPS) * 16'(in_flight);

    case (state_q)
      S_IDLE: begin
        lat_d = 2'd0;
        if (en && n_wvf_in_buf != 10'd0) begin
          hdr_rdreq_d = 1'b1;
          state_d     = S_HDR;
        end
      end
      S_HDR: begin
        lat_d = lat_q + 2'd1;
        if (lat_q == 2'(RD_LAT)) begin
          w0_d     = {4'hA, hdr_data[7:6], hdr_data[5], hdr_data[4:0], 4'h0};
          ltc_d    = hdr_data[79:32];
          len_d    = {1'b0, len_diff} + 13'd1;
          hw_idx_d = 3'd0;
          issue_d  = '0;
          recv_d   = '0;
          state_d  = S_HDRW;
        end
      end
      S_HDRW: begin
        if (cnt_q < DEPTH_C) begin
          push0    = 1'b1;
          hw_idx_d = hw_idx_q + 3'd1;
          case (hw_idx_q)
            3'd0:    d0 = {1'b0, w0_q};
            3'd1:    d0 = {1'b0, 3'b000, len_q};
            3'd2:    d0 = {1'b0, ltc_q[47:32]};
            3'd3:    d0 = {1'b0, ltc_q[31:16]};
            default: d0 = {1'b0, ltc_q[15:0]};
          endcase
          if (hw_idx_q == 3'd4) state_d = S_SMP;
        end
      end
      S_SMP: begin
        issue_d = issue_q + {12'b0, wvb_rdreq_q};
        if (issue_d < len_q && committed <= CREDIT_C) wvb_rdreq_d = 1'b1;
        if (rd_pipe_q[RD_LAT-1]) begin
          recv_d = recv_q + 13'd1;
          err_d  = err_q | (is_last ? !eoe : eoe);
          push0  = 1'b1;
`ifdef WVB_RD_DISCR_EN
          d0    = {1'b0, eoe, wvb_data[1], 2'b00, wvb_data[13:2]};
          push1 = 1'b1;
          d1    = {is_last, 8'h00, wvb_data[21:14]};
`else
          d0    = {is_last, eoe, wvb_data[1], 2'b00, wvb_data[13:2]};
`endif
        end
        if (pop && head[16]) state_d = S_DONE;
      end
      S_DONE: begin
        evt_cnt_d = evt_cnt_q + 16'd1;
        state_d   = S_HOLD;
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_d = mem_q;
    if (push0) mem_d[wr_ptr_q] = d0;
    if (push1) mem_d[wr_ptr_q + AW'(1)] = d1;
    wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      hw_idx_q    <= '0;
      w0_q        <= '0;
      ltc_q       <= '0;
      len_q       <= '0;
      issue_q     <= '0;
      recv_q      <= '0;
      rd_pipe_q   <= '0;
      hdr_rdreq_q <= 1'b0;
      wvb_rdreq_q <= 1'b0;
      err_q       <= 1'b0;
      evt_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      hw_idx_q    <= hw_idx_d;
      w0_q        <= w0_d;
      ltc_q       <= ltc_d;
      len_q       <= len_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
      rd_pipe_q   <= rd_pipe_d;
      hdr_rdreq_q <= hdr_rdreq_d;
      wvb_rdreq_q <= wvb_rdreq_d;
      err_q       <= err_d;
      evt_cnt_q   <= evt_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign hdr_rdreq  = hdr_rdreq_q;
  assign wvb_rdreq  = wvb_rdreq_q;
  assign wvb_rddone = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign err_eoe    = err_q;
  assign evt_cnt    = evt_cnt_q;
  assign dout_valid = (cnt_q != '0);
  assign dout       = dout_valid ? head[15:0] : 16'h0000;
  assign dout_last  = dout_valid & head[16];

endmodule

`default_nettype wire
